mem_arbiter_rr: RTL and testbench
=================================

// Module: mem_arbiter_rr
// PURPOSE
// - N-requester main-memory arbiter with integrated block-fill engine; successor to the two-cache arbiter.
// - Sits between NUM_REQ cache miss interfaces plus one write-through port and a pipelined main memory.
// - Grants misses round-robin, streams BLOCK_WORDS reads per fill and routes returning words to the granted cache.
// PARAMETERS
// - NUM_REQ      2   number of cache requesters (>=2)
// - ADDR_W       16  byte address width
// - DATA_W       16  word width; address step per word = DATA_W/8
// - BLOCK_WORDS  8   words per cache block (power of 2, >=2)
// PORTS
// - clk          in   1                 clock; all state updates on rising edge
// - rst          in   1                 synchronous, active-high reset
// - miss_req     in   NUM_REQ           level miss request per cache; held until its fill_tag_we pulse
// - miss_addr    in   NUM_REQ*ADDR_W    flattened miss addresses; slice i = [i*ADDR_W +: ADDR_W]
// - fill_data    out  DATA_W            word being written into the granted cache
// - fill_addr    out  ADDR_W            byte address of fill_data
// - fill_we      out  NUM_REQ           one-hot data-array write strobe
// - fill_tag_we  out  NUM_REQ           one-hot, 1-cycle tag-array write strobe (fill complete)
// - busy         out  1                 fill in progress (state != IDLE)
// - stall_n      out  1                 ~(busy | |miss_req)
// - wr_en        in   1                 write-through request
// - wr_addr      in   ADDR_W            write address
// - wr_data      in   DATA_W            write data
// - wr_ready     out  1                 write accepted this cycle (state==IDLE)
// - mem_addr     out  ADDR_W            memory address
// - mem_rd       out  1                 read issue; memory accepts one per cycle, returns in order
// - mem_wr       out  1                 memory write strobe
// - mem_wdata    out  DATA_W            memory write data
// - mem_rdata    in   DATA_W            read return data
// - mem_rvalid   in   1                 read return valid
// BEHAVIOUR
// - Reset: state=IDLE, issue/rx counters=0, rr_ptr=0, grant=0; every output 0 except stall_n=~|miss_req.
// - States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
// - IDLE: wr_en has priority: mem_wr=wr_en, mem_addr=wr_addr, mem_wdata=wr_data, wr_ready=1, no grant.
//   Otherwise, if |miss_req: grant = first set bit searching upward from rr_ptr with wrap; base = miss_addr
//   with low log2(BLOCK_WORDS*DATA_W/8) bits cleared; -> ISSUE next cycle.
// - ISSUE: mem_rd=1 every cycle; mem_addr = base + issue_cnt*(DATA_W/8); after BLOCK_WORDS issues -> DRAIN.
// - mem_rvalid (ISSUE or DRAIN): fill_we[grant]=1, fill_data=mem_rdata, fill_addr=base + rx_cnt*step,
//   same cycle (0 added latency); rx_cnt++.
// - Last return (rx_cnt==BLOCK_WORDS-1 && mem_rvalid) -> DONE. Valid on the last issue cycle is legal.
// - DONE (1 cycle): fill_tag_we[grant]=1; rr_ptr <= (grant+1) mod NUM_REQ; -> IDLE.
// - mem_rvalid in IDLE or DONE: ignored, no strobe. wr_en outside IDLE: ignored, wr_ready=0.
// - Counters are log2(BLOCK_WORDS)+1 bits wide; address arithmetic wraps modulo 2^ADDR_W.
// - A miss_req deasserted mid-fill does not abort the fill; it completes normally.
// - rst mid-fill: immediate return to reset state; any in-flight memory returns are dropped (IDLE ignore).
// - Simultaneous miss_req on all requesters: one fill each, in rr order, with no starvation.
// CONFIGURATION
// - ARB_CWF_EN defined: critical word first. Issue and return order start at the miss word offset and wrap
//   within the block (offset, offset+1, ..., BLOCK_WORDS-1, 0, ...). fill_addr follows the same order.
// - ARB_CWF_EN undefined: always ascending from offset 0.
// TESTING
// - Reset, miss_req=2'b01, addr 0x1236, mem latency 3: 8 reads 0x1230..0x123E, 8 fill_we[0], 1 fill_tag_we[0].
// - miss_req=2'b11 held: req0 filled first, then req1; rr_ptr=1 after first, so a re-raised req0 waits.
// - wr_en with miss_req=2'b10 in IDLE: mem_wr=1 and wr_ready=1 that cycle; req1 fill starts next cycle.
// - ARB_CWF_EN, miss addr 0x00FA: read order 0x00FA,0x00FC,0x00FE,0x00F0..0x00F8; fill_addr matches.
// - rst pulse after 3 returns: busy=0 next cycle, late mem_rvalid produces no fill_we, fresh miss refills.
// - miss addr 0xFFF2, step 2: block 0xFFF0..0xFFFE, no overflow into 0x0000.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// Round-robin main-memory arbiter with an integrated block-fill engine for NUM_REQ caches plus a write-through port.
// Define ARB_CWF_EN to issue and return each fill critical-word-first, wrapping within the block.
module mem_arbiter_rr #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        miss_req,
  input  logic [NUM_REQ*ADDR_W-1:0] miss_addr,
  output logic [DATA_W-1:0]         fill_data,
  output logic [ADDR_W-1:0]         fill_addr,
  output logic [NUM_REQ-1:0]        fill_we,
  output logic [NUM_REQ-1:0]        fill_tag_we,
  output logic                      busy,
  output logic                      stall_n,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_rvalid
);
  localparam int unsigned STEP      = DATA_W / 8;
  localparam int unsigned WORD_W    = $clog2(BLOCK_WORDS);
  localparam int unsigned CNT_W     = WORD_W + 1;
  localparam int unsigned GNT_W     = $clog2(NUM_REQ);
  localparam int unsigned BLK_BYTES = BLOCK_WORDS * STEP;

  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(BLK_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP_A   = ADDR_W'(STEP);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [GNT_W-1:0]  LAST_REQ = GNT_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [GNT_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [GNT_W-1:0]  grant_q, grant_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic [WORD_W-1:0] issue_word;
  logic [WORD_W-1:0] rx_word;
  logic [GNT_W-1:0]  pick;
  logic              pick_vld;
  logic [ADDR_W-1:0] pick_addr;
  logic [ADDR_W-1:0] req_addr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign req_addr[i] = miss_addr[i*ADDR_W +: ADDR_W];
  end
  assign pick_addr = req_addr[pick];

  // Requester index k positions above ptr, wrapping at NUM_REQ.
  function automatic logic [GNT_W-1:0] rr_idx(input logic [GNT_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= int'(NUM_REQ)) s = s - int'(NUM_REQ);
    return GNT_W'(s);
  endfunction

  // Scan downward so the nearest requester at or above rr_ptr wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (miss_req[rr_idx(rr_ptr_q, k)]) begin
        pick     = rr_idx(rr_ptr_q, k);
        pick_vld = 1'b1;
      end
    end
  end

`ifdef ARB_CWF_EN
  logic [WORD_W-1:0] offset_q, offset_d;

  // Word offset of the missing address, latched at grant; counters walk the block from it.
  always_comb begin
    offset_d = offset_q;
    if (state_q == IDLE && !wr_en && pick_vld)
      offset_d = WORD_W'(pick_addr >> $clog2(STEP));
  end

  always_ff @(posedge clk) begin
    if (rst) offset_q <= '0;
    else     offset_q <= offset_d;
  end

  assign issue_word = WORD_W'(issue_cnt_q) + offset_q;
  assign rx_word    = WORD_W'(rx_cnt_q) + offset_q;
`else
  assign issue_word = WORD_W'(issue_cnt_q);
  assign rx_word    = WORD_W'(rx_cnt_q);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      base_q      <= base_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    base_d      = base_q;
    fill_data   = '0;
    fill_addr   = '0;
    fill_we     = '0;
    fill_tag_we = '0;
    wr_ready    = 1'b0;
    mem_addr    = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_wdata   = '0;

    case (state_q)
      IDLE: begin
        if (wr_en) begin
          mem_wr    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
          wr_ready  = 1'b1;
        end else if (pick_vld) begin
          grant_d     = pick;
          base_d      = pick_addr & BLK_MASK;
          issue_cnt_d = '0;
          rx_cnt_d    = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        mem_rd      = 1'b1;
        mem_addr    = base_q + ADDR_W'(issue_word) * STEP_A;
        issue_cnt_d = issue_cnt_q + CNT_W'(1);
        if (issue_cnt_q == LAST_CNT) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = DRAIN;
      end
      DONE: begin
        fill_tag_we[grant_q] = 1'b1;
        rr_ptr_d             = (grant_q == LAST_REQ) ? '0 : grant_q + GNT_W'(1);
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Returns pass straight through to the granted cache; the last one may land on the last issue cycle.
    if ((state_q == ISSUE || state_q == DRAIN) && mem_rvalid) begin
      fill_we[grant_q] = 1'b1;
      fill_data        = mem_rdata;
      fill_addr        = base_q + ADDR_W'(rx_word) * STEP_A;
      rx_cnt_d         = rx_cnt_q + CNT_W'(1);
      if (rx_cnt_q == LAST_CNT) state_d = DONE;
    end
  end

  assign busy    = (state_q != IDLE);
  assign stall_n = ~(busy | (|miss_req));

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr: expected memory reads, fills, tag strobes and writes are queued
// by the stimulus from a request-level model; an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_mem_arbiter_rr;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned BW      = 8;
  localparam int unsigned STEP    = DATA_W / 8;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        miss_req = '0;
  logic [NUM_REQ*ADDR_W-1:0] miss_addr = '0;
  logic [DATA_W-1:0]         fill_data;
  logic [ADDR_W-1:0]         fill_addr;
  logic [NUM_REQ-1:0]        fill_we;
  logic [NUM_REQ-1:0]        fill_tag_we;
  logic                      busy;
  logic                      stall_n;
  logic                      wr_en = 1'b0;
  logic [ADDR_W-1:0]         wr_addr = '0;
  logic [DATA_W-1:0]         wr_data = '0;
  logic                      wr_ready;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_rd;
  logic                      mem_wr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata = '0;
  logic                      mem_rvalid = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_rr #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .fill_data(fill_data), .fill_addr(fill_addr), .fill_we(fill_we), .fill_tag_we(fill_tag_we),
    .busy(busy), .stall_n(stall_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

`ifdef ARB_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pipelined memory: accepts one read per cycle, returns in order after lat cycles.
  typedef struct { logic [DATA_W-1:0] data; int unsigned due; } ret_t;
  ret_t        ret_q[$];
  int unsigned lat = 3;

  always @(posedge clk) begin
    #1;
    if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = ret_q[0].data;
      void'(ret_q.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = DATA_W'($urandom);
    end
    #1;
    if (mem_rd) ret_q.push_back('{data: DATA_W'($urandom), due: cyc + lat});
  end

  typedef struct { int unsigned req; logic [ADDR_W-1:0] addr; } fill_t;
  logic [ADDR_W-1:0]        exp_rd_q[$];
  fill_t                    exp_fill_q[$];
  int unsigned              exp_tag_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
  int unsigned              reraise [NUM_REQ];
  int unsigned              model_rr = 0;

  logic [ADDR_W-1:0]        mon_a;
  fill_t                    mon_f;
  int unsigned              mon_r;
  logic [ADDR_W+DATA_W-1:0] mon_w;

  // Monitor: compares every DUT event against the head of its expectation queue.
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (mem_rd) begin
        chk(exp_rd_q.size() != 0, "mem_rd_expected", 64'(mem_addr), 0);
        if (exp_rd_q.size() != 0) begin
          mon_a = exp_rd_q.pop_front();
          chk(mem_addr == mon_a, "mem_rd_addr", 64'(mem_addr), 64'(mon_a));
        end
      end
      if (fill_we != '0) begin
        chk(exp_fill_q.size() != 0, "fill_we_expected", 64'(fill_we), 0);
        if (exp_fill_q.size() != 0) begin
          mon_f = exp_fill_q.pop_front();
          chk(fill_we == NUM_REQ'(1 << mon_f.req), "fill_we_onehot", 64'(fill_we), 64'(1 << mon_f.req));
          chk(fill_addr == mon_f.addr, "fill_addr", 64'(fill_addr), 64'(mon_f.addr));
          chk(fill_data == mem_rdata, "fill_data", 64'(fill_data), 64'(mem_rdata));
          chk(busy == 1'b1, "busy_during_fill", 64'(busy), 1);
        end
      end
      if (fill_tag_we != '0) begin
        chk(exp_tag_q.size() != 0, "tag_we_expected", 64'(fill_tag_we), 0);
        if (exp_tag_q.size() != 0) begin
          mon_r = exp_tag_q.pop_front();
          chk(fill_tag_we == NUM_REQ'(1 << mon_r), "fill_tag_we", 64'(fill_tag_we), 64'(1 << mon_r));
          if (reraise[mon_r] > 0) reraise[mon_r]--;
          else miss_req[mon_r] = 1'b0;
        end
      end
      if (mem_wr) begin
        chk(exp_wr_q.size() != 0, "mem_wr_expected", 64'(mem_addr), 0);
        if (exp_wr_q.size() != 0) begin
          mon_w = exp_wr_q.pop_front();
          chk({mem_addr, mem_wdata} == mon_w, "mem_wr_addr_data", 64'({mem_addr, mem_wdata}), 64'(mon_w));
        end
      end
      if (wr_ready != mem_wr) chk(1'b0, "wr_ready_vs_mem_wr", 64'(wr_ready), 64'(mem_wr));
      if (miss_req != '0) chk(stall_n == 1'b0, "stall_n_with_miss", 64'(stall_n), 0);
    end
  end

  // Expected reads and fills for one block, in the order the block is walked.
  task automatic plan_fill(input int unsigned req, input logic [ADDR_W-1:0] a);
    int unsigned base, off, word;
    logic [ADDR_W-1:0] wa;
    base = int'(a) - (int'(a) % (BW * STEP));
    off  = CWF ? (int'(a) / STEP) % BW : 0;
    for (int k = 0; k < int'(BW); k++) begin
      word = (off + k) % BW;
      wa   = ADDR_W'(base + word * STEP);
      exp_rd_q.push_back(wa);
      exp_fill_q.push_back('{req: req, addr: wa});
    end
    exp_tag_q.push_back(req);
    model_rr = (req + 1) % NUM_REQ;
  endtask

  // Request-level arbitration model: cnt[r] fills wanted per requester, all pending together.
  task automatic run_batch(input int unsigned cnt [NUM_REQ], input logic [ADDR_W-1:0] addr [NUM_REQ]);
    int unsigned rem [NUM_REQ];
    int unsigned left, r;
    left = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rem[i] = cnt[i];
      left  += cnt[i];
    end
    while (left > 0) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        r = (model_rr + k) % NUM_REQ;
        if (rem[r] > 0) break;
      end
      plan_fill(r, addr[r]);
      rem[r]--;
      left--;
    end
    @(posedge clk); #1;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (cnt[i] > 0) begin
        reraise[i] = cnt[i] - 1;
        miss_addr[i*ADDR_W +: ADDR_W] = addr[i];
        miss_req[i] = 1'b1;
      end
    end
  endtask

  task automatic wait_empty(input string name);
    int unsigned n = 0;
    while ((exp_rd_q.size() + exp_fill_q.size() + exp_tag_q.size() + exp_wr_q.size()) != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk(n < 400, name, 64'(n), 400);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_fills(input int unsigned want);
    int unsigned seen = 0, n = 0;
    while (seen < want && n < 200) begin
      @(posedge clk); #2;
      if (fill_we != '0) seen++;
      n++;
    end
    chk(seen == want, "wait_fills_timeout", 64'(seen), 64'(want));
  endtask

  int unsigned       cnt  [NUM_REQ];
  logic [ADDR_W-1:0] addr [NUM_REQ];
  int unsigned       nlate;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(NUM_REQ); i++) reraise[i] = 0;
    repeat (3) @(posedge clk);
    #2;
    chk(busy == 1'b0, "reset_busy", 64'(busy), 0);
    chk(stall_n == 1'b1, "reset_stall_n", 64'(stall_n), 1);
    chk({fill_we, fill_tag_we, mem_rd, mem_wr, wr_ready} == '0, "reset_strobes",
        64'({fill_we, fill_tag_we, mem_rd, mem_wr, wr_ready}), 0);
    chk({mem_addr, fill_addr, fill_data, mem_wdata} == '0, "reset_buses",
        64'({mem_addr, fill_addr, fill_data, mem_wdata}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single miss on req0, latency 3.
    lat = 3;
    cnt[0] = 1; cnt[1] = 0; addr[0] = 16'h1236; addr[1] = 16'h0000;
    run_batch(cnt, addr);
    wait_empty("single_miss_timeout");

    // req1 alone, then both held with req0 re-raised: expect 0, 1, 0.
    cnt[0] = 0; cnt[1] = 1; addr[1] = 16'h4A58;
    run_batch(cnt, addr);
    wait_empty("req1_timeout");
    lat = 2;
    cnt[0] = 2; cnt[1] = 1; addr[0] = 16'h2002; addr[1] = 16'h7BCE;
    run_batch(cnt, addr);
    wait_empty("rr_pair_timeout");

    // Write with a pending req1 miss: write wins this cycle, fill follows.
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 16'hBEEF; wr_data = 16'h1234;
    exp_wr_q.push_back({16'hBEEF, 16'h1234});
    cnt[0] = 0; cnt[1] = 1; addr[1] = 16'h3330;
    plan_fill(1, addr[1]);
    miss_addr[ADDR_W +: ADDR_W] = addr[1];
    miss_req[1] = 1'b1;
    #1;
    chk(wr_ready == 1'b1, "wr_ready_idle", 64'(wr_ready), 1);
    chk(busy == 1'b0, "busy_on_write", 64'(busy), 0);
    @(posedge clk); #1;
    wr_en = 1'b0;
    wait_empty("write_then_fill_timeout");

    // Write during a fill is refused.
    lat = 4;
    cnt[0] = 1; cnt[1] = 0; addr[0] = 16'h5558;
    run_batch(cnt, addr);
    wait_fills(1);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 16'h0102; wr_data = 16'hCAFE;
    #1;
    chk(wr_ready == 1'b0, "wr_ready_busy", 64'(wr_ready), 0);
    chk(mem_wr == 1'b0, "mem_wr_busy", 64'(mem_wr), 0);
    @(posedge clk); #1;
    wr_en = 1'b0;
    wait_empty("busy_write_timeout");

    // Top-of-memory block and the critical-word example address.
    lat = 1;
    cnt[0] = 0; cnt[1] = 1; addr[1] = 16'hFFF2;
    run_batch(cnt, addr);
    wait_empty("top_block_timeout");
    lat = 3;
    cnt[0] = 1; cnt[1] = 0; addr[0] = 16'h00FA;
    run_batch(cnt, addr);
    wait_empty("cwf_example_timeout");

    // Reset after 3 returns of a req1 fill; late returns must be dropped, rr pointer back to 0.
    lat = 4;
    cnt[0] = 0; cnt[1] = 1; addr[1] = 16'h9994;
    run_batch(cnt, addr);
    wait_fills(3);
    @(posedge clk); #1;
    rst = 1'b1;
    miss_req = '0;
    exp_rd_q.delete(); exp_fill_q.delete(); exp_tag_q.delete();
    reraise[0] = 0; reraise[1] = 0;
    model_rr = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk(busy == 1'b0, "busy_after_rst", 64'(busy), 0);
    chk({fill_we, mem_rd} == '0, "strobes_after_rst", 64'({fill_we, mem_rd}), 0);
    nlate = 0;
    while (ret_q.size() != 0 && nlate < 20) begin
      @(posedge clk); #2;
      if (mem_rvalid) chk(fill_we == '0, "late_rvalid_fill_we", 64'(fill_we), 0);
      nlate++;
    end
    repeat (3) @(posedge clk);
    cnt[0] = 1; cnt[1] = 1; addr[0] = 16'h6660; addr[1] = 16'h1110;
    run_batch(cnt, addr);
    wait_empty("post_rst_timeout");

    // Randomised batches.
    for (int t = 0; t < 8; t++) begin
      lat = $urandom_range(1, 4);
      cnt[0] = $urandom_range(0, 2);
      cnt[1] = $urandom_range(0, 2);
      if (cnt[0] + cnt[1] == 0) cnt[t % 2] = 1;
      addr[0] = ADDR_W'($urandom);
      addr[1] = ADDR_W'($urandom);
      run_batch(cnt, addr);
      wait_empty("random_batch_timeout");
    end

    chk(miss_req == '0, "final_miss_req", 64'(miss_req), 0);
    chk(busy == 1'b0, "final_busy", 64'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
